matmul_sched: RTL

Sequencer for the 4x4 systolic matmul FU. It accepts a full A/B matrix pair through a valid/ready command port and drives the FU start pulse and step counter. Each cycle it generates the skewed diagonal lane inputs, collects the four result rows as the FU emits them, and presents the assembled 4x4 product on a valid/ready result port. It sits between the issue logic and the FU and replaces hand-sequenced feeding.

---
 rtl/matmul_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/matmul_sched.sv
// Sequencer for the 4x4 systolic matmul FU: latches an A/B pair, feeds skewed lanes, gathers result rows.
// Command port stalls (cmd_ready=0) while busy; the result is held in DONE until res_ready.
module matmul_sched #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [16*DW-1:0]    cmd_a_flat,
   input  logic [16*DW-1:0]    cmd_b_flat,
   output logic                fu_start,
   output logic [3:0]          fu_counter,
   output logic [4*DW-1:0]     fu_inA_flat,
   output logic [4*DW-1:0]     fu_inB_flat,
   input  logic                fu_output_rdy,
   input  logic [4*DW-1:0]     fu_outD_flat,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [16*DW-1:0]    res_flat,
   output logic                busy,
   output logic                err_timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   state_t              state_q;
   logic                sub_q;
   logic [3:0]          cnt_q;
   logic [1:0]          idx_q;
   logic [TW-1:0]       run_cnt_q;
   logic [16*DW-1:0]    a_q;
   logic [16*DW-1:0]    b_q;
   logic [4*DW-1:0]     row_q [4];
   logic                err_q;

   // Word 0 of a packed matrix sits in the MSBs.
   function automatic logic [DW-1:0] word(input logic [16*DW-1:0] m, input int w);
      return m[(15-w)*DW +: DW];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sub_q     <= 1'b0;
         cnt_q     <= 4'd0;
         idx_q     <= 2'd0;
         run_cnt_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         err_q     <= 1'b0;
         for (int r = 0; r < 4; r++) row_q[r] <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  a_q     <= cmd_a_flat;
                  b_q     <= cmd_b_flat;
                  idx_q   <= 2'd0;
                  sub_q   <= 1'b0;
                  cnt_q   <= 4'd0;
                  state_q <= START;
               end
            end
            START: begin
               sub_q <= 1'b1;
               if (sub_q) begin
                  state_q   <= RUN;
                  cnt_q     <= 4'd1;
                  run_cnt_q <= '0;
               end
            end
            RUN: begin
               if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
               run_cnt_q <= run_cnt_q + TW'(1);
               if (fu_output_rdy) begin
                  row_q[idx_q] <= fu_outD_flat;
                  idx_q        <= idx_q + 2'd1;
               end
               // A fourth row arriving on the expiry cycle still completes the job.
               if (fu_output_rdy && idx_q == 2'd3) begin
                  state_q <= DONE;
                  cnt_q   <= 4'd0;
               end else if (run_cnt_q == TW'(TIMEOUT - 1)) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  cnt_q   <= 4'd0;
               end
            end
            DONE: begin
               if (res_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Lane i carries A[i][k] and B[k][i] with k = 4+i-c while c is in [i+1, i+4].
   always_comb begin
      fu_inA_flat = '0;
      fu_inB_flat = '0;
      for (int i = 0; i < 4; i++) begin
         if (state_q == RUN && cnt_q >= 4'(i + 1) && cnt_q <= 4'(i + 4)) begin
            fu_inA_flat[(3-i)*DW +: DW] = word(a_q, 4*i + (4 + i - int'(cnt_q)));
            fu_inB_flat[(3-i)*DW +: DW] = word(b_q, 4*(4 + i - int'(cnt_q)) + i);
         end
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign fu_start    = (state_q == START);
   assign res_valid   = (state_q == DONE);
   assign fu_counter  = cnt_q;
   assign err_timeout = err_q;
   assign res_flat    = {row_q[0], row_q[1], row_q[2], row_q[3]};

endmodule
